// File: rtl/mem_bus_master_if.sv
// Request/response channel and memory-bus signals of the mem_bus_master initiator.
// The master modport is the initiator's view; slave is the CPU core plus memory side.
interface mem_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_rw;
  logic [31:0] mem_abus;
  logic [31:0] mem_dbus_out;
  logic [31:0] mem_dbus_in;

  modport master (
    input  req_valid, req_rw, req_addr, req_wdata, rsp_ready, mem_dbus_in,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_en, mem_rw, mem_abus, mem_dbus_out
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_wdata, rsp_ready, mem_dbus_in,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_en, mem_rw, mem_abus, mem_dbus_out
  );
endinterface

// File: rtl/mem_bus_master.sv
// Single-outstanding initiator for the en/rw/abus/dbus word memory: one request in,
// a fixed-length bus access window, then one response out.
module mem_bus_master #(
  parameter int unsigned MEM_BYTES   = 128,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic              clock,
  input logic              reset,
  mem_bus_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [31:0] MAX_ADDR  = 32'(MEM_BYTES - 4);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        err_q, err_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_rw_q, mem_rw_d;
  logic [31:0] mem_abus_q, mem_abus_d;
  logic [31:0] mem_dbus_out_q, mem_dbus_out_d;

  logic req_fire;
  logic req_bad;

  assign bus.req_ready = (state_q == IDLE) && !reset;
  assign req_fire      = bus.req_valid && bus.req_ready;
  assign req_bad       = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr > MAX_ADDR);

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch can leave a signal unassigned and infer a latch.
    state_d        = state_q;
    wait_d         = wait_q;
    err_d          = err_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_err_d      = rsp_err_q;
    rsp_rdata_d    = rsp_rdata_q;
    mem_en_d       = mem_en_q;
    mem_rw_d       = mem_rw_q;
    mem_abus_d     = mem_abus_q;
    mem_dbus_out_d = mem_dbus_out_q;

    case (state_q)
      IDLE: begin
        if (req_fire) begin
          state_d = ACCESS;
          if (req_bad) begin
            // A rejected request spends one ACCESS cycle with the bus idle, so the
            // error response appears one edge after accept.
            err_d  = 1'b1;
            wait_d = 4'd0;
          end else begin
            mem_en_d       = 1'b1;
            mem_rw_d       = bus.req_rw;
            mem_abus_d     = bus.req_addr;
            mem_dbus_out_d = bus.req_rw ? 32'd0 : bus.req_wdata;
            wait_d         = WAIT_INIT;
          end
        end
      end

      ACCESS: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          rsp_rdata_d    = (mem_en_q && mem_rw_q) ? bus.mem_dbus_in : 32'd0;
          rsp_err_d      = err_q;
          rsp_valid_d    = 1'b1;
          err_d          = 1'b0;
          mem_en_d       = 1'b0;
          mem_rw_d       = 1'b1;
          mem_dbus_out_d = 32'd0;
          state_d        = RESP;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      wait_q         <= 4'd0;
      err_q          <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_rdata_q    <= 32'd0;
      mem_en_q       <= 1'b0;
      mem_rw_q       <= 1'b1;
      mem_abus_q     <= 32'd0;
      mem_dbus_out_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      err_q          <= err_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_err_q      <= rsp_err_d;
      rsp_rdata_q    <= rsp_rdata_d;
      mem_en_q       <= mem_en_d;
      mem_rw_q       <= mem_rw_d;
      mem_abus_q     <= mem_abus_d;
      mem_dbus_out_q <= mem_dbus_out_d;
    end
  end

  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.mem_en       = mem_en_q;
  assign bus.mem_rw       = mem_rw_q;
  assign bus.mem_abus     = mem_abus_q;
  assign bus.mem_dbus_out = mem_dbus_out_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: directed vector table, hand sequences for
// backpressure, wait-state sweep and reset mid-access, then random traffic against a word-array model.
module tb_mem_bus_master;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_bus_master_if bus ();
  mem_bus_master_if bus0 ();
  mem_bus_master_if bus3 ();

  mem_bus_master #(.MEM_BYTES(128), .WAIT_CYCLES(1)) dut  (.clock(clock), .reset(reset), .bus(bus));
  mem_bus_master #(.MEM_BYTES(128), .WAIT_CYCLES(0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
  mem_bus_master #(.MEM_BYTES(128), .WAIT_CYCLES(3)) dut3 (.clock(clock), .reset(reset), .bus(bus3));

  // Memory environment: image reloaded while reset is high, writes land during the mem_en window.
  logic [31:0] mem_arr [32];

  function automatic logic [31:0] img_word(input int i);
    case (i)
      0:       return 32'h002F_000C;
      2:       return 32'hA5A5_0008;
      3:       return 32'h0C0C_0C0C;
      5:       return 32'h0000_0001;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem_arr[i] <= img_word(i);
    end else if (bus.mem_en && !bus.mem_rw) begin
      mem_arr[bus.mem_abus[6:2]] <= bus.mem_dbus_out;
    end
  end

  assign bus.mem_dbus_in  = (bus.mem_en && bus.mem_rw)   ? mem_arr[bus.mem_abus[6:2]]  : 32'hDEAD_BEEF;
  assign bus0.mem_dbus_in = (bus0.mem_en && bus0.mem_rw) ? mem_arr[bus0.mem_abus[6:2]] : 32'hDEAD_BEEF;
  assign bus3.mem_dbus_in = (bus3.mem_en && bus3.mem_rw) ? mem_arr[bus3.mem_abus[6:2]] : 32'hDEAD_BEEF;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_en;
  } vec_t;

  typedef struct {
    bit          got;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          en_cyc;
    bit          bus_ok;
  } res_t;

  // Reference model: flat word array plus the acceptance rules.
  logic [31:0] ref_mem [32];

  function automatic bit ref_is_err(input logic [31:0] addr);
    return (addr % 4 != 0) || (addr > 32'd124);
  endfunction

  task automatic do_txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, output res_t r);
    int guard;
    r.got = 0; r.err = 1'b0; r.rdata = 32'd0; r.lat = 0; r.en_cyc = 0; r.bus_ok = 1;
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.rsp_ready = 1'b0;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(posedge clock); #1; guard++;
    end
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    while (!bus.rsp_valid && r.lat < 50) begin
      if (bus.mem_en) begin
        r.en_cyc++;
        if (bus.mem_rw !== rw || bus.mem_abus !== addr ||
            bus.mem_dbus_out !== (rw ? 32'd0 : wdata)) r.bus_ok = 0;
      end
      @(posedge clock); #1; r.lat++;
    end
    if (!bus.rsp_valid) return;
    r.got   = 1;
    r.err   = bus.rsp_err;
    r.rdata = bus.rsp_rdata;
    if (bus.mem_en) r.bus_ok = 0;
    repeat (hold) begin
      @(posedge clock); #1;
      if (!bus.rsp_valid || bus.rsp_rdata !== r.rdata || bus.rsp_err !== r.err || bus.req_ready)
        r.bus_ok = 0;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clock); #1;
    bus.rsp_ready = 1'b0;
    if (bus.rsp_valid || !bus.req_ready) r.bus_ok = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
    check({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
    check({tag, "_mem_rw"}, 32'(bus.mem_rw), 32'd1);
    check({tag, "_mem_abus"}, bus.mem_abus, 32'd0);
    check({tag, "_mem_dbus_out"}, bus.mem_dbus_out, 32'd0);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
  endtask

  vec_t        vecs [10];
  res_t        r;
  int          guard;
  bit          ok;
  int          lat0, lat3, en0, en3;
  logic [31:0] rd0, rd3;
  logic        t_rw;
  logic [31:0] t_addr, t_wdata, t_exp_rdata;
  logic        t_exp_err;
  int          sel;

  initial begin
    bus.req_valid = 1'b0; bus.req_rw = 1'b1; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    bus.rsp_ready = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_rw = 1'b1; bus0.req_addr = 32'd0; bus0.req_wdata = 32'd0;
    bus0.rsp_ready = 1'b1;
    bus3.req_valid = 1'b0; bus3.req_rw = 1'b1; bus3.req_addr = 32'd0; bus3.req_wdata = 32'd0;
    bus3.rsp_ready = 1'b1;
    for (int i = 0; i < 32; i++) ref_mem[i] = img_word(i);

    //            rw    addr           wdata          err   rdata          lat en
    vecs[0] = '{1'b0, 32'h0000_0004, 32'h0000_003A, 1'b0, 32'h0000_0000, 2, 2};
    vecs[1] = '{1'b1, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'h0000_003A, 2, 2};
    vecs[2] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h002F_000C, 2, 2};
    vecs[3] = '{1'b1, 32'h0000_0014, 32'h0000_0000, 1'b0, 32'h0000_0001, 2, 2};
    vecs[4] = '{1'b1, 32'h0000_0006, 32'h0000_0000, 1'b1, 32'h0000_0000, 1, 0};
    vecs[5] = '{1'b1, 32'h0000_0080, 32'h0000_0000, 1'b1, 32'h0000_0000, 1, 0};
    vecs[6] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 32'h0000_0000, 1, 0};
    vecs[7] = '{1'b0, 32'h0000_007C, 32'h1234_5678, 1'b0, 32'h0000_0000, 2, 2};
    vecs[8] = '{1'b1, 32'h0000_007C, 32'h0000_0000, 1'b0, 32'h1234_5678, 2, 2};
    vecs[9] = '{1'b0, 32'h0000_007D, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1, 0};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    #1;
    check("reset_release_ready", 32'(bus.req_ready), 32'd1);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      do_txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, 0, r);
      check($sformatf("vec%0d_got", i), 32'(r.got), 32'd1);
      check($sformatf("vec%0d_err", i), 32'(r.err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_rdata", i), r.rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_latency", i), 32'(r.lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_en_cycles", i), 32'(r.en_cyc), 32'(vecs[i].exp_en));
      check($sformatf("vec%0d_bus", i), 32'(r.bus_ok), 32'd1);
      if (!vecs[i].exp_err && !vecs[i].rw) ref_mem[vecs[i].addr / 4] = vecs[i].wdata;
    end

    // Backpressure with a second request waiting
    bus.req_valid = 1'b1; bus.req_rw = 1'b1; bus.req_addr = 32'h08; bus.rsp_ready = 1'b0;
    @(posedge clock); #1;
    check("bp_accept_ready", 32'(bus.req_ready), 32'd0);
    bus.req_addr = 32'h0C;
    guard = 0;
    while (!bus.rsp_valid && guard < 20) begin @(posedge clock); #1; guard++; end
    check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("bp_rdata", bus.rsp_rdata, 32'hA5A5_0008);
    ok = 1;
    repeat (5) begin
      @(posedge clock); #1;
      if (!bus.rsp_valid || bus.rsp_rdata !== 32'hA5A5_0008 || bus.req_ready) ok = 0;
    end
    check("bp_hold_stable", 32'(ok), 32'd1);
    bus.rsp_ready = 1'b1;
    @(posedge clock); #1;
    bus.rsp_ready = 1'b0;
    check("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_release_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    check("bp_second_accept", 32'(bus.mem_en), 32'd1);
    check("bp_second_addr", bus.mem_abus, 32'h0C);
    guard = 0;
    while (!bus.rsp_valid && guard < 20) begin @(posedge clock); #1; guard++; end
    check("bp_second_rdata", bus.rsp_rdata, 32'h0C0C_0C0C);
    bus.rsp_ready = 1'b1;
    @(posedge clock); #1;
    bus.rsp_ready = 1'b0;

    // Wait-state sweep: WAIT_CYCLES = 0 and 3 side by side
    check("sweep_ready0", 32'(bus0.req_ready), 32'd1);
    check("sweep_ready3", 32'(bus3.req_ready), 32'd1);
    bus0.req_valid = 1'b1; bus0.req_addr = 32'h0C;
    bus3.req_valid = 1'b1; bus3.req_addr = 32'h0C;
    @(posedge clock); #1;
    bus0.req_valid = 1'b0; bus3.req_valid = 1'b0;
    lat0 = -1; lat3 = -1; en0 = 0; en3 = 0; rd0 = 32'd0; rd3 = 32'd0;
    for (int c = 0; c < 8; c++) begin
      if (bus0.mem_en) en0++;
      if (bus3.mem_en) en3++;
      if (bus0.rsp_valid && lat0 < 0) begin lat0 = c; rd0 = bus0.rsp_rdata; end
      if (bus3.rsp_valid && lat3 < 0) begin lat3 = c; rd3 = bus3.rsp_rdata; end
      @(posedge clock); #1;
    end
    check("sweep_w0_latency", 32'(lat0), 32'd1);
    check("sweep_w0_en_cycles", 32'(en0), 32'd1);
    check("sweep_w0_rdata", rd0, 32'h0C0C_0C0C);
    check("sweep_w3_latency", 32'(lat3), 32'd4);
    check("sweep_w3_en_cycles", 32'(en3), 32'd4);
    check("sweep_w3_rdata", rd3, 32'h0C0C_0C0C);

    // Random traffic against the reference model
    for (int i = 0; i < 150; i++) begin
      t_rw    = 1'($urandom_range(0, 1));
      t_wdata = $urandom;
      sel     = int'($urandom_range(0, 9));
      if (sel < 7)       t_addr = 32'($urandom_range(0, 31)) * 4;
      else if (sel == 7) t_addr = 32'($urandom_range(0, 127)) | 32'd1;
      else if (sel == 8) t_addr = 32'($urandom_range(128, 4096)) & ~32'd3;
      else               t_addr = $urandom;
      t_exp_err   = ref_is_err(t_addr);
      t_exp_rdata = (!t_exp_err && t_rw) ? ref_mem[t_addr / 4] : 32'd0;
      if (!t_exp_err && !t_rw) ref_mem[t_addr / 4] = t_wdata;
      do_txn(t_rw, t_addr, t_wdata, int'($urandom_range(0, 3)), r);
      check($sformatf("rnd%0d_got", i), 32'(r.got), 32'd1);
      check($sformatf("rnd%0d_err", i), 32'(r.err), 32'(t_exp_err));
      check($sformatf("rnd%0d_rdata", i), r.rdata, t_exp_rdata);
      check($sformatf("rnd%0d_latency", i), 32'(r.lat), t_exp_err ? 32'd1 : 32'd2);
      check($sformatf("rnd%0d_en_cycles", i), 32'(r.en_cyc), t_exp_err ? 32'd0 : 32'd2);
      check($sformatf("rnd%0d_bus", i), 32'(r.bus_ok), 32'd1);
    end

    // Reset during the second ACCESS cycle of a write
    bus.req_valid = 1'b1; bus.req_rw = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h55;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    @(posedge clock); #1;
    check("rst_mid_pre_en", 32'(bus.mem_en), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    check_reset_outputs("rst_mid");
    reset = 1'b0;
    #1;
    check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    ok = 1;
    repeat (5) begin
      @(posedge clock); #1;
      if (bus.rsp_valid || bus.mem_en) ok = 0;
    end
    check("rst_mid_no_rsp", 32'(ok), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
